// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix load/store path: width ladder, error codes
// and the loader FSM state encoding.
package matrix_pkg;

    typedef enum logic [1:0] {
        S_ROW  = 2'd0,
        S_COL  = 2'd1,
        S_DATA = 2'd2
    } load_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DIM     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Bits needed to index n entries, never less than one bit.
    function automatic int width_ladder(input int n);
        if (n <= 2)
            return 1;
        else if (n <= 4)
            return 2;
        else if (n <= 8)
            return 3;
        else if (n <= 16)
            return 4;
        else if (n <= 32)
            return 5;
        else if (n <= 64)
            return 6;
        else
            return 7;
    endfunction

    function automatic int matrix_idx_w(input int matrix_num);
        return width_ladder(matrix_num);
    endfunction

    function automatic int addr_in_w(input int max_size);
        return width_ladder(max_size * max_size);
    endfunction

    function automatic int sel_idx_w(input int matrix_num);
        return width_ladder(matrix_num);
    endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte gap timer: reload on each received byte, count while enabled,
// flag expiry once LIMIT cycles have passed since the byte was taken.
module rx_timeout_timer #(
    parameter int LIMIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic reload,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_r;

    // The reload value of 1 counts the byte's own cycle, so expiry lands LIMIT cycles after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CW'(0);
        end else if (srst) begin
            cnt_r <= CW'(0);
        end else if (reload) begin
            cnt_r <= CW'(1);
        end else if (en && (cnt_r != CW'(LIMIT - 1))) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = en && (cnt_r == CW'(LIMIT - 1));

endmodule

// File: rtl/uart_matrix_loader.sv
// Parses framed matrices (rows, cols, row-major elements) from the UART byte
// stream and drives the write port of the multi-matrix storage.
module uart_matrix_loader
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_SIZE    = 5,
    parameter int MATRIX_NUM  = 8,
    parameter int CLK_FREQ    = 100000000,
    parameter int TIMEOUT_MS  = 1000,
    localparam int MATRIX_IDX_W = matrix_idx_w(MATRIX_NUM),
    localparam int ADDR_IN_W    = addr_in_w(MAX_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic                    matrix_wr_en,
    output logic [MATRIX_IDX_W-1:0] matrix_idx,
    output logic [2:0]              store_row,
    output logic [2:0]              store_col,
    output logic [ADDR_IN_W-1:0]    wr_addr_in,
    output logic [DATA_WIDTH-1:0]   matrix_wr_data,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_err,
    output logic [1:0]              err_code
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int PROD_W         = 6;

    load_state_e              state_r;
    logic [2:0]               rows_r;
    logic [2:0]               cols_r;
    logic [PROD_W-1:0]        total_r;
    logic [ADDR_IN_W-1:0]     elem_r;
    logic [MATRIX_IDX_W-1:0]  slot_r;
    logic                     expire_s;
    logic                     dim_ok_s;
    logic                     frame_open_s;
    logic                     last_elem_s;

    assign dim_ok_s     = (rx_data >= DATA_WIDTH'(1)) && (rx_data <= DATA_WIDTH'(MAX_SIZE));
    assign frame_open_s = (state_r == S_COL) || (state_r == S_DATA);
    assign last_elem_s  = (PROD_W'(elem_r) == (total_r - PROD_W'(1)));

    rx_timeout_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .srst   (1'b0),
        .reload (rx_valid),
        .en     (frame_open_s),
        .expire (expire_s)
    );

    // Frame parser FSM with registered write-port and status outputs; a timeout outranks a same-cycle byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_ROW;
            rows_r         <= 3'd0;
            cols_r         <= 3'd0;
            total_r        <= PROD_W'(0);
            elem_r         <= ADDR_IN_W'(0);
            slot_r         <= MATRIX_IDX_W'(0);
            matrix_wr_en   <= 1'b0;
            matrix_idx     <= MATRIX_IDX_W'(0);
            store_row      <= 3'd0;
            store_col      <= 3'd0;
            wr_addr_in     <= ADDR_IN_W'(0);
            matrix_wr_data <= DATA_WIDTH'(0);
            load_busy      <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            err_code       <= ERR_NONE;
        end else begin
            matrix_wr_en <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            if (expire_s) begin
                state_r   <= S_ROW;
                load_busy <= 1'b0;
                load_err  <= 1'b1;
                err_code  <= ERR_TIMEOUT;
            end else if (rx_valid) begin
                case (state_r)
                    S_ROW: begin
                        if (dim_ok_s) begin
                            rows_r    <= rx_data[2:0];
                            state_r   <= S_COL;
                            load_busy <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                            err_code <= ERR_DIM;
                        end
                    end
                    S_COL: begin
                        if (dim_ok_s) begin
                            cols_r  <= rx_data[2:0];
                            total_r <= PROD_W'(rows_r) * PROD_W'(rx_data[2:0]);
                            elem_r  <= ADDR_IN_W'(0);
                            state_r <= S_DATA;
                        end else begin
                            state_r   <= S_ROW;
                            load_busy <= 1'b0;
                            load_err  <= 1'b1;
                            err_code  <= ERR_DIM;
                        end
                    end
                    S_DATA: begin
                        matrix_wr_en   <= 1'b1;
                        matrix_wr_data <= rx_data;
                        wr_addr_in     <= elem_r;
                        store_row      <= rows_r;
                        store_col      <= cols_r;
                        matrix_idx     <= slot_r;
                        if (last_elem_s) begin
                            load_done <= 1'b1;
                            load_busy <= 1'b0;
                            state_r   <= S_ROW;
                            if (slot_r == MATRIX_IDX_W'(MATRIX_NUM - 1)) begin
                                slot_r <= MATRIX_IDX_W'(0);
                            end else begin
                                slot_r <= slot_r + MATRIX_IDX_W'(1);
                            end
                        end else begin
                            elem_r <= elem_r + ADDR_IN_W'(1);
                        end
                    end
                    default: begin
                        state_r   <= S_ROW;
                        load_busy <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Randomised and directed bench for uart_matrix_loader against a frame-level
// reference model; 10-cycle inter-byte timeout (CLK_FREQ 10000, TIMEOUT_MS 1).
module tb_uart_matrix_loader;

    localparam int TO_CYC = 10000 / 1000 * 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       matrix_wr_en;
    logic [2:0] matrix_idx;
    logic [2:0] store_row;
    logic [2:0] store_col;
    logic [4:0] wr_addr_in;
    logic [7:0] matrix_wr_data;
    logic       load_busy;
    logic       load_done;
    logic       load_err;
    logic [1:0] err_code;

    uart_matrix_loader #(
        .DATA_WIDTH (8),
        .MAX_SIZE   (5),
        .MATRIX_NUM (8),
        .CLK_FREQ   (10000),
        .TIMEOUT_MS (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .matrix_wr_en   (matrix_wr_en),
        .matrix_idx     (matrix_idx),
        .store_row      (store_row),
        .store_col      (store_col),
        .wr_addr_in     (wr_addr_in),
        .matrix_wr_data (matrix_wr_data),
        .load_busy      (load_busy),
        .load_done      (load_done),
        .load_err       (load_err),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_edge = 0;

    // reference model state: frame progress kept as plain counts
    bit m_have_rows = 1'b0;
    bit m_have_cols = 1'b0;
    int m_rows = 0, m_cols = 0, m_n = 0, m_slot = 0, m_last = 0;
    logic       e_wr_en = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [2:0] e_idx = 3'd0, e_row = 3'd0, e_col = 3'd0;
    logic [4:0] e_addr = 5'd0;
    logic [7:0] e_data = 8'd0;
    logic [1:0] e_code = 2'd0;

    typedef struct {
        int         at;
        logic       wr_en;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] code;
        logic [2:0] idx;
        logic [2:0] row;
        logic [2:0] col;
        logic [4:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t ev_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] dut_vec();
        return {matrix_wr_en, matrix_idx, store_row, store_col, wr_addr_in,
                matrix_wr_data, load_busy, load_done, load_err, err_code};
    endfunction

    function automatic bit legal_dim(input logic [7:0] d);
        return (d >= 8'd1) && (d <= 8'd5);
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_have_rows = 1'b0; m_have_cols = 1'b0; m_slot = 0; m_n = 0;
            e_wr_en = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
            e_idx = 3'd0; e_row = 3'd0; e_col = 3'd0; e_addr = 5'd0;
            e_data = 8'd0; e_code = 2'd0;
        end else begin
            cyc++;
            e_wr_en = 1'b0; e_done = 1'b0; e_err = 1'b0;
            if (m_have_rows && (cyc - m_last == TO_CYC - 1)) begin
                e_err = 1'b1; e_code = 2'b10;
                m_have_rows = 1'b0; m_have_cols = 1'b0;
            end else if (rx_valid) begin
                m_last = cyc;
                if (!m_have_rows) begin
                    if (legal_dim(rx_data)) begin
                        m_rows = int'(rx_data); m_have_rows = 1'b1;
                    end else begin
                        e_err = 1'b1; e_code = 2'b01;
                    end
                end else if (!m_have_cols) begin
                    if (legal_dim(rx_data)) begin
                        m_cols = int'(rx_data); m_have_cols = 1'b1; m_n = 0;
                    end else begin
                        e_err = 1'b1; e_code = 2'b01; m_have_rows = 1'b0;
                    end
                end else begin
                    e_wr_en = 1'b1; e_addr = 5'(m_n); e_data = rx_data;
                    e_row = 3'(m_rows); e_col = 3'(m_cols); e_idx = 3'(m_slot);
                    m_n++;
                    if (m_n == m_rows * m_cols) begin
                        e_done = 1'b1;
                        m_slot = (m_slot + 1) % 8;
                        m_have_rows = 1'b0; m_have_cols = 1'b0;
                    end
                end
            end
            e_busy = m_have_rows;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // compare every cycle on the falling edge and log interesting cycles
    initial forever begin
        @(negedge clk);
        check($sformatf("cycle%0d_outputs", cyc), 32'(dut_vec()),
              32'({e_wr_en, e_idx, e_row, e_col, e_addr, e_data, e_busy, e_done, e_err, e_code}));
        if (matrix_wr_en || load_done || load_err)
            ev_log.push_back('{cyc, matrix_wr_en, load_busy, load_done, load_err, err_code,
                               matrix_idx, store_row, store_col, wr_addr_in, matrix_wr_data});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(posedge clk);
        #1;
        last_edge = cyc;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic reset_dut();
        rx_valid = 1'b0;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        ev_log.delete();
    endtask

    task automatic rand_gap();
        int sel;
        sel = int'($urandom_range(0, 19));
        if (sel < 12)       idle(0);
        else if (sel < 16)  idle(int'($urandom_range(1, 3)));
        else if (sel == 16) idle(7);
        else if (sel == 17) idle(8);
        else if (sel == 18) idle(9);
        else                idle(12);
    endtask

    function automatic int pick_dim();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) return 0;
        if (sel == 1) return int'($urandom_range(6, 255));
        return int'($urandom_range(1, 5));
    endfunction

    initial begin
        int r, c, cnt, err_at;
        idle(2);
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        reset_dut();

        // 2x3 frame back-to-back
        send_byte(8'h02); send_byte(8'h03);
        for (int i = 0; i < 6; i++) send_byte(8'h0A + 8'(i));
        idle(3);
        check("A_writes", 32'(ev_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (ev_log.size() > i) begin
                check($sformatf("A_addr%0d", i), 32'(ev_log[i].addr), 32'(i));
                check($sformatf("A_data%0d", i), 32'(ev_log[i].data), 32'(8'h0A + 8'(i)));
                check($sformatf("A_dims%0d", i), 32'({ev_log[i].idx, ev_log[i].row, ev_log[i].col}),
                      32'({3'd0, 3'd2, 3'd3}));
                check($sformatf("A_done%0d", i), 32'(ev_log[i].done), 32'(i == 5));
                check($sformatf("A_busy%0d", i), 32'(ev_log[i].busy), 32'(i != 5));
            end
        end

        // illegal rows 06 then 00, then a 1x1 frame proves the parser still expects rows
        reset_dut();
        send_byte(8'h06); idle(2);
        check("B_rows06_events", 32'(ev_log.size()), 32'd1);
        if (ev_log.size() > 0)
            check("B_rows06_err", 32'({ev_log[0].wr_en, ev_log[0].err, ev_log[0].code}), 32'({1'b0, 1'b1, 2'b01}));
        ev_log.delete();
        send_byte(8'h00); idle(2);
        if (ev_log.size() > 0)
            check("B_rows00_err", 32'({ev_log[0].wr_en, ev_log[0].err, ev_log[0].code}), 32'({1'b0, 1'b1, 2'b01}));
        else
            check("B_rows00_events", 32'(ev_log.size()), 32'd1);
        ev_log.delete();
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h55); idle(2);
        if (ev_log.size() > 0)
            check("B_reload", 32'({ev_log[0].done, ev_log[0].idx, ev_log[0].addr, ev_log[0].data}),
                  32'({1'b1, 3'd0, 5'd0, 8'h55}));
        else
            check("B_reload_events", 32'(ev_log.size()), 32'd1);

        // bad cols then clean reload
        reset_dut();
        send_byte(8'h01); send_byte(8'h00); idle(2);
        if (ev_log.size() > 0)
            check("C_cols_err", 32'({ev_log[0].err, ev_log[0].code, ev_log[0].busy}), 32'({1'b1, 2'b01, 1'b0}));
        else
            check("C_cols_events", 32'(ev_log.size()), 32'd1);
        ev_log.delete();
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h55); idle(2);
        if (ev_log.size() > 0)
            check("C_reload", 32'({ev_log[0].done, ev_log[0].idx, ev_log[0].data}), 32'({1'b1, 3'd0, 8'h55}));
        else
            check("C_reload_events", 32'(ev_log.size()), 32'd1);

        // timeout: byte 11 occupies the cycle before edge last_edge, err shows 10 cycles later
        reset_dut();
        send_byte(8'h02); send_byte(8'h02); send_byte(8'h11);
        r = last_edge;
        idle(15);
        err_at = -1; cnt = 0;
        foreach (ev_log[i]) begin
            if (ev_log[i].err) begin err_at = ev_log[i].at; c = int'(ev_log[i].code); end
            if (ev_log[i].done) cnt++;
        end
        check("D_err_delay", 32'(err_at - r), 32'(TO_CYC - 1));
        if (err_at >= 0) check("D_err_code", 32'(c), 32'd2);
        check("D_no_done", 32'(cnt), 32'd0);
        ev_log.delete();
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h77); idle(2);
        if (ev_log.size() > 0)
            check("D_same_slot", 32'(ev_log[0].idx), 32'd0);
        else
            check("D_next_events", 32'(ev_log.size()), 32'd1);

        // nine 1x1 frames walk the slot counter through its wrap
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h01); send_byte(8'h01); send_byte(8'(i + 8'h30));
        end
        idle(2);
        check("E_frames", 32'(ev_log.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            if (ev_log.size() > i)
                check($sformatf("E_idx%0d", i), 32'({ev_log[i].done, ev_log[i].idx}), 32'({1'b1, 3'(i % 8)}));

        // reset in the middle of a 3x3 frame
        reset_dut();
        send_byte(8'h03); send_byte(8'h03);
        for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
        idle(1);
        rst_n = 1'b0;
        #1;
        check("F_async_zero", 32'(dut_vec()), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        cnt = 0;
        foreach (ev_log[i]) if (ev_log[i].done || ev_log[i].err) cnt++;
        check("F_writes", 32'(ev_log.size()), 32'd3);
        check("F_no_pulse", 32'(cnt), 32'd0);
        ev_log.delete();
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h99); idle(2);
        if (ev_log.size() > 0)
            check("F_after", 32'({ev_log[0].done, ev_log[0].idx, ev_log[0].addr, ev_log[0].data}),
                  32'({1'b1, 3'd0, 5'd0, 8'h99}));
        else
            check("F_after_events", 32'(ev_log.size()), 32'd1);

        // randomised frames with illegal dimensions, collisions and timeouts mixed in
        reset_dut();
        for (int f = 0; f < 60; f++) begin
            r = pick_dim();
            send_byte(8'(r)); rand_gap();
            if (r >= 1 && r <= 5) begin
                c = pick_dim();
                send_byte(8'(c)); rand_gap();
                if (c >= 1 && c <= 5)
                    for (int k = 0; k < r * c; k++) begin
                        send_byte(8'($urandom_range(0, 255)));
                        rand_gap();
                    end
            end
        end
        idle(15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_matrix_loader.md
Name: uart_matrix_loader

Overview:
- Receive-side counterpart of the matrix-to-UART transmit path.
- Consumes the byte stream from uart_rx and parses framed matrices (rows, cols, then elements in row-major order).
- Drives the write port of multi_matrix_storage (wr_en, matrix_idx, store_row, store_col, wr_addr_in, wr_data).
- Sits between uart_rx and multi_matrix_storage in the top level; the storage module is the sink.

Parameters:
- DATA_WIDTH, 8, element width and UART byte width.
- MAX_SIZE, 5, largest legal row or col value.
- MATRIX_NUM, 8, number of global storage slots; slot index wraps modulo this value.
- CLK_FREQ, 100000000, clock frequency in Hz.
- TIMEOUT_MS, 1000, maximum gap between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  DATA_WIDTH  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle
- matrix_wr_en  out  1  one-cycle storage write strobe
- matrix_idx  out  MATRIX_IDX_W  target slot (MATRIX_IDX_W = 3 at default)
- store_row  out  3  row count of the frame being loaded
- store_col  out  3  col count of the frame being loaded
- wr_addr_in  out  ADDR_IN_W  linear element index r*cols+c (ADDR_IN_W = 5 at default)
- matrix_wr_data  out  DATA_WIDTH  element value
- load_busy  out  1  high while a frame is in progress
- load_done  out  1  one-cycle pulse when a frame completes
- load_err  out  1  one-cycle pulse when a frame is aborted
- err_code  out  2  01 = bad dimension, 10 = timeout; holds its value until the next error or reset

Behaviour:
- Reset (async, rst_n = 0):
  - All outputs are 0.
  - FSM goes to S_ROW; slot counter, element counter and timeout counter clear.
- FSM states: S_ROW, S_COL, S_DATA.
- S_ROW:
  - On rx_valid, if 1 <= rx_data <= MAX_SIZE: latch rows, go to S_COL, load_busy = 1 from the next cycle.
  - Otherwise stay in S_ROW; next cycle load_err = 1 and err_code = 01.
- S_COL: same range check for cols.
  - Legal: latch cols, clear the element counter, go to S_DATA.
  - Illegal: go to S_ROW and pulse the error as in S_ROW.
- S_DATA, on each rx_valid, registered with 1-cycle latency (byte at cycle T produces outputs at T+1):
  - matrix_wr_en = 1, matrix_wr_data = byte, wr_addr_in = element counter.
  - store_row / store_col = latched dimensions; matrix_idx = current slot.
  - Element counter increments.
- Last element (counter = rows*cols-1):
  - At T+1: load_done = 1 together with the final wr_en.
  - Slot counter increments, wrapping MATRIX_NUM-1 -> 0.
  - FSM returns to S_ROW at T+1, so a byte arriving at T+1 is parsed as the next rows byte with no byte lost.
- rows*cols is computed once when cols is latched (3x3-bit product, at most 25), not per byte.
- Timeout:
  - Counter reloads on every rx_valid and counts only in S_COL or S_DATA.
  - When it reaches CLK_FREQ/1000*TIMEOUT_MS-1: go to S_ROW, load_err = 1, err_code = 10.
  - The slot does not advance; elements already written stay in storage but are not committed.
- load_busy is 1 exactly in S_COL and S_DATA (registered).
- rx_valid in the same cycle a timeout expires: timeout wins and the byte is dropped.
- Reset mid-frame aborts with no done or err pulse; the slot counter returns to 0.
- matrix_idx, store_row and store_col hold their last values when wr_en = 0.

Decomposition:
- Shared package matrix_pkg:
  - MATRIX_IDX_W / ADDR_IN_W / SEL_IDX_W width functions (the same ladder the storage uses).
  - err_code constants ERR_NONE = 00, ERR_DIM = 01, ERR_TIMEOUT = 10.
  - FSM state encoding.
- One sub-module: rx_timeout_timer (reload, enable, expire pulse), reusable by future command parsers.

Test Plan:
- Bytes 02,03,0A..0F back-to-back ->
  - six wr_en pulses, addr 0..5, data 0A..0F, store_row = 2, store_col = 3, matrix_idx = 0;
  - load_done coincides with the addr 5 write;
  - load_busy falls the same cycle.
- Rows byte 06 -> no wr_en, load_err pulse, err_code = 01, still in S_ROW.
- Rows 00 also -> load_err pulse, err_code = 01, still in S_ROW.
- Bytes 01, 00 -> error pulse, then bytes 01,01,55 load cleanly at idx 0.
- TIMEOUT_MS = 1 with CLK_FREQ = 10000 (10-cycle timeout); send 02,02,11 then idle ->
  - load_err with err_code = 10 exactly 10 cycles after the 11 byte;
  - next frame also uses idx 0.
- Load nine 1x1 frames -> matrix_idx sequence 0,1,...,7,0; nine load_done pulses.
- Assert rst_n = 0 after 3 of 9 elements of a 3x3 frame ->
  - all outputs 0 immediately, no done or err pulse;
  - the following 1x1 frame writes idx 0, addr 0.
